paddle_input_arbiter: RTL and testbench
=======================================

// Module: paddle_input_arbiter
// PURPOSE
//  Owns left-paddle control. Arbitrates among three sources: PocketBeagle GPIO (pb_up/pb_down),
//  keyboard W/S (key_fsm outputs) and an optional built-in ball-tracking auto-player.
//  Drives the w_pressed/s_pressed inputs of main_game_coordinator.
//  Instantiated in top, which ties its move_up/move_down outputs to those inputs.
// PARAMETERS
//  SYNC_STAGES     2        flops in each pb_* metastability synchronizer (>=2)
//  DEBOUNCE_CYCLES 50000    cycles a synced pb_* level must stay stable before it is accepted
//  IDLE_TIMEOUT    200000000  cycles with no activity from the owning source before ownership is released
// PORTS
//  clk          in   1  system clock (100 MHz)
//  reset        in   1  asynchronous, active-high; clears all state
//  pb_up        in   1  PocketBeagle up request; asynchronous pin
//  pb_down      in   1  PocketBeagle down request; asynchronous pin
//  kb_up        in   1  keyboard W held; synchronous to clk
//  kb_down      in   1  keyboard S held; synchronous to clk
//  ball_zone    in   3  ball Y zone, 0 = top .. 7 = bottom
//  paddle_zone  in   3  left paddle centre Y zone, 0..7
//  move_up      out  1  registered; paddle moves up
//  move_down    out  1  registered; paddle moves down
//  src_sel      out  2  registered owner: 0 = AUTO, 1 = PB, 2 = KB (3 never driven)
//  src_change   out  1  one-cycle pulse, asserted in the same cycle src_sel takes a new value
// BEHAVIOUR
//  Reset
//  - All outputs 0; src_sel = AUTO.
//  - Synchronizers, debounced levels and both counters cleared.
//  - Asserting reset mid-operation clears the same state immediately, with no clock needed.
//  Input conditioning
//  - pb_* pass through SYNC_STAGES flops.
//  - Per-bit debounce counter clears when the synced value differs from the debounced value.
//  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced value takes the synced value.
//  - kb_* are used directly.
//  Activity
//  - pb_act = pb_up_db | pb_down_db.
//  - kb_act = kb_up | kb_down.
//  FSM (state is src_sel) priority PB > KB > AUTO; evaluated each cycle, registered next edge:
//  - any state, pb_act=1                          -> PB
//  - AUTO, kb_act=1, pb_act=0                     -> KB
//  - KB, kb_act=0 and idle counter == TIMEOUT-1   -> AUTO
//  - PB, pb_act=0 and idle counter == TIMEOUT-1   -> KB if kb_act, else AUTO
//  - PB, kb_act=1: ignored (no preemption of PB by KB)
//  Idle counter
//  - Clears on every state change and on every cycle the owning source is active.
//  - Otherwise increments; saturates at IDLE_TIMEOUT-1.
//  - In AUTO it is held at 0.
//  Direction (source = current src_sel; registered, 1-cycle latency from sel/input to outputs)
//  - PB:   up = pb_up_db & ~pb_down_db;  down = pb_down_db & ~pb_up_db
//  - KB:   same rule on kb_up/kb_down
//  - AUTO: up = ball_zone < paddle_zone;  down = ball_zone > paddle_zone; equal -> neither
//  - Both requests high -> both outputs 0. move_up & move_down is never 1.
//  Latency
//  - pb pin edge to move_*: SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles (+1 when ownership changes).
//  - kb to move_*: 1 cycle if already owner, else 2.
//  - src_change is high exactly one cycle per transition; it never fires on reset release.
//  Width rules
//  - Counters sized with $clog2(param+1).
//  - Zone comparisons are unsigned 3-bit.
// CONFIGURATION
//  PADDLE_ARB_AUTO_EN
//  - Defined: AUTO state drives the ball-tracking rule above.
//  - Undefined: tracking logic is not built. In AUTO, move_up = move_down = 0 (paddle idle until
//    PB or KB claims it). FSM, src_sel and ports are unchanged.
// TESTING (bench params: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, IDLE_TIMEOUT=20)
//  1 Reset, ball_zone=2, paddle_zone=5 (AUTO_EN) -> src_sel=0; move_up=1 on first edge after reset.
//  2 kb_up=1 in AUTO -> src_sel=2 with src_change pulse next edge; move_up=1 following edge.
//    Drop kb_up; after 20 idle cycles -> src_sel=0.
//  3 pb_down pulse 3 cycles wide -> rejected by debounce; src_sel unchanged.
//    pb_down held -> src_sel=1 after 2+4+1 cycles; move_down=1 one cycle later.
//  4 In PB, kb_up=1 and pb released -> src_sel stays 1 for 20 cycles, then -> 2; move_up=1.
//  5 PB owner, pb_up and pb_down both debounced high -> move_up=move_down=0 while src_sel=1.
//  6 Reset asserted mid-PB (between edges) -> outputs 0, src_sel=0 with no clock edge.
//    Repeat 1 with AUTO_EN undefined -> move_* stay 0.

Source files
------------

// File: rtl/paddle_input_arbiter_if.sv
// paddle_input_arbiter_if: paddle source inputs and arbitrated move/owner outputs
// master: drives pb_*/kb_*/zones, reads move_*/src_*; slave: the arbiter side
interface paddle_input_arbiter_if;
  logic pb_up, pb_down, kb_up, kb_down;
  logic [2:0] ball_zone, paddle_zone;
  logic move_up, move_down, src_change;
  logic [1:0] src_sel;
  modport master (
    output pb_up, pb_down, kb_up, kb_down, ball_zone, paddle_zone,
    input move_up, move_down, src_sel, src_change
  );
  modport slave (
    input pb_up, pb_down, kb_up, kb_down, ball_zone, paddle_zone,
    output move_up, move_down, src_sel, src_change
  );
endinterface

// File: rtl/paddle_input_arbiter.sv
// paddle_input_arbiter: left-paddle owner arbitration (PB > KB > AUTO) with pb sync/debounce
// Ports: clk, reset (async, active-high), bus (slave): pb_up/pb_down async pins,
//   kb_up/kb_down, ball_zone/paddle_zone in; move_up/move_down, src_sel (0 AUTO,1 PB,2 KB),
//   src_change out, all registered.
// Build option: define PADDLE_ARB_AUTO_EN to build ball tracking; otherwise AUTO leaves move_* at 0.
module paddle_input_arbiter #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int IDLE_TIMEOUT = 200000000
) (
  input logic clk,
  input logic reset,
  paddle_input_arbiter_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [IW-1:0] I_MAX = IW'(IDLE_TIMEOUT - 1);
  typedef enum logic [1:0] {AUTO = 2'd0, PB = 2'd1, KB = 2'd2} src_t;
  src_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync_up, sync_dn;
  logic [1:0] synced, db;
  logic [DW-1:0] db_cnt [2];
  logic [IW-1:0] idle, idle_nx;
  logic pb_act, kb_act, own_act, idle_done, up_nx, dn_nx, auto_up, auto_dn;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync_up <= '0;
      sync_dn <= '0;
    end else begin
      sync_up <= {sync_up[SYNC_STAGES-2:0], bus.pb_up};
      sync_dn <= {sync_dn[SYNC_STAGES-2:0], bus.pb_down};
    end
  assign synced = {sync_dn[SYNC_STAGES-1], sync_up[SYNC_STAGES-1]};
  // The counter only runs while synced disagrees with the accepted level, so any
  // return to the accepted level before the count completes discards the change.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      db <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (synced[i] == db[i]) db_cnt[i] <= '0;
        else if (db_cnt[i] == D_MAX) begin
          db[i] <= synced[i];
          db_cnt[i] <= '0;
        end else db_cnt[i] <= db_cnt[i] + DW'(1);
    end
  assign pb_act = |db;
  assign kb_act = bus.kb_up | bus.kb_down;
  assign idle_done = idle == I_MAX;
  assign own_act = (state == PB) ? pb_act : (state == KB) ? kb_act : 1'b0;
`ifdef PADDLE_ARB_AUTO_EN
  assign auto_up = bus.ball_zone < bus.paddle_zone;
  assign auto_dn = bus.ball_zone > bus.paddle_zone;
`else
  assign auto_up = 1'b0;
  assign auto_dn = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    state_nx = pb_act ? PB
      : (state == AUTO && kb_act) ? KB
      : (state == KB && !kb_act && idle_done) ? AUTO
      : (state == PB && idle_done) ? (kb_act ? KB : AUTO)
      : state;
    idle_nx = (state_nx != state || state == AUTO || own_act) ? '0
      : idle_done ? idle : idle + IW'(1);
  end
  assign up_nx = (state == PB) ? (db[0] & ~db[1])
    : (state == KB) ? (bus.kb_up & ~bus.kb_down) : auto_up;
  assign dn_nx = (state == PB) ? (db[1] & ~db[0])
    : (state == KB) ? (bus.kb_down & ~bus.kb_up) : auto_dn;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= AUTO;
      idle <= '0;
      bus.move_up <= 1'b0;
      bus.move_down <= 1'b0;
      bus.src_change <= 1'b0;
    end else begin
      state <= state_nx;
      idle <= idle_nx;
      bus.move_up <= up_nx;
      bus.move_down <= dn_nx;
      bus.src_change <= state_nx != state;
    end
  assign bus.src_sel = state;
endmodule

// File: tb/tb_paddle_input_arbiter.sv
// tb_paddle_input_arbiter: directed and random checks of paddle_input_arbiter against a timeline model
module tb_paddle_input_arbiter;
  localparam int SYNC = 2, DEB = 4, IDLE = 20;
  logic clk = 1'b0, reset = 1'b1;
  int n_cmp = 0, n_bad = 0, lat;
  paddle_input_arbiter_if bus();
  paddle_input_arbiter #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .IDLE_TIMEOUT(IDLE)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  int m_src, m_edge, m_clr;
  bit m_up, m_dn, m_chg, db_up, db_dn;
  bit hu[$], hd[$];
  task automatic model_reset();
    m_src = 0;
    m_edge = 0;
    m_clr = 0;
    {m_up, m_dn, m_chg, db_up, db_dn} = '0;
    hu.delete();
    hd.delete();
    repeat (SYNC + DEB) begin
      hu.push_back(1'b0);
      hd.push_back(1'b0);
    end
  endtask
  // Oldest DEB entries are the synchronized pin over the last DEB edges.
  function automatic bit settle(bit h[$], bit cur);
    for (int k = 1; k < DEB; k++) if (h[k] != h[0]) return cur;
    return h[0];
  endfunction
  task automatic model_tick();
    bit pa, ka, done, own;
    int ns;
    m_edge++;
    pa = db_up | db_dn;
    ka = bus.kb_up | bus.kb_down;
    done = (m_edge - 1 - m_clr) >= IDLE - 1;
    ns = pa ? 1 : (m_src == 0 && ka) ? 2 : (m_src == 2 && !ka && done) ? 0
      : (m_src == 1 && done) ? (ka ? 2 : 0) : m_src;
    own = (m_src == 1) ? pa : (m_src == 2) ? ka : 1'b0;
    if (ns != m_src || m_src == 0 || own) m_clr = m_edge;
    if (m_src == 1) begin
      m_up = db_up && !db_dn;
      m_dn = db_dn && !db_up;
    end else if (m_src == 2) begin
      m_up = bus.kb_up && !bus.kb_down;
      m_dn = bus.kb_down && !bus.kb_up;
    end else begin
`ifdef PADDLE_ARB_AUTO_EN
      m_up = bus.ball_zone < bus.paddle_zone;
      m_dn = bus.ball_zone > bus.paddle_zone;
`else
      m_up = 1'b0;
      m_dn = 1'b0;
`endif
    end
    m_chg = ns != m_src;
    m_src = ns;
    hu.push_back(bus.pb_up);
    hd.push_back(bus.pb_down);
    void'(hu.pop_front());
    void'(hd.pop_front());
    db_up = settle(hu, db_up);
    db_dn = settle(hd, db_dn);
  endtask
  function automatic logic [4:0] obs();
    return {bus.src_sel, bus.move_up, bus.move_down, bus.src_change};
  endfunction
  task automatic chk(string tag, logic [4:0] got, logic [4:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(string tag, int n = 1);
    repeat (n) begin
      model_tick();
      @(posedge clk);
      #1;
      chk(tag, obs(), {2'(m_src), m_up, m_dn, m_chg});
    end
  endtask
  initial begin
    {bus.pb_up, bus.pb_down, bus.kb_up, bus.kb_down} = '0;
    bus.ball_zone = 3'd2;
    bus.paddle_zone = 3'd5;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", obs(), 5'd0);
    reset = 1'b0;
    model_reset();
    step("auto_first");
`ifdef PADDLE_ARB_AUTO_EN
    chk("auto_track", {3'd0, bus.move_up, bus.move_down}, 5'b00010);
`else
    chk("auto_track", {3'd0, bus.move_up, bus.move_down}, 5'b00000);
`endif
    bus.kb_up = 1'b1;
    step("kb_claim");
    step("kb_move");
    chk("kb_move_up", {bus.src_sel, bus.move_up, 2'b00}, 5'b10100);
    bus.kb_up = 1'b0;
    lat = 0;
    while (bus.src_sel != 2'd0 && lat < 60) begin
      step("kb_idle");
      lat++;
    end
    chk("kb_release_lat", 5'(lat), 5'(IDLE));
    bus.pb_down = 1'b1;
    step("pb_glitch", 3);
    bus.pb_down = 1'b0;
    step("pb_glitch_after", 8);
    chk("glitch_sel", {3'd0, bus.src_sel}, 5'd0);
    bus.pb_down = 1'b1;
    lat = 0;
    while (bus.src_sel != 2'd1 && lat < 30) begin
      step("pb_hold");
      lat++;
    end
    chk("pb_claim_lat", 5'(lat), 5'(SYNC + DEB + 1));
    step("pb_move");
    chk("pb_move_down", {bus.src_sel, bus.move_up, bus.move_down, 1'b0}, 5'b01010);
    bus.kb_up = 1'b1;
    bus.pb_down = 1'b0;
    lat = 0;
    while (bus.src_sel != 2'd2 && lat < 60) begin
      step("pb_to_kb");
      lat++;
    end
    chk("pb_release_lat", 5'(lat), 5'(SYNC + DEB + IDLE));
    step("kb_after_pb");
    chk("kb_after_pb_up", {bus.src_sel, bus.move_up, 2'b00}, 5'b10100);
    bus.kb_up = 1'b0;
    bus.pb_up = 1'b1;
    bus.pb_down = 1'b1;
    step("pb_both", 12);
    chk("pb_both_idle", {bus.src_sel, bus.move_up, bus.move_down, 1'b0}, 5'b01000);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", obs(), 5'd0);
    {bus.pb_up, bus.pb_down} = '0;
    bus.ball_zone = 3'd2;
    bus.paddle_zone = 3'd5;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    step("auto_repeat", 2);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(31) == 0) bus.pb_up = 1'($urandom);
      if ($urandom_range(31) == 0) bus.pb_down = 1'($urandom);
      if ($urandom_range(15) == 0) bus.kb_up = 1'($urandom);
      if ($urandom_range(15) == 0) bus.kb_down = 1'($urandom);
      bus.ball_zone = 3'($urandom);
      bus.paddle_zone = 3'($urandom);
      step("random");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
